// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8N1 / 8E1 / 8O1 frames, LSB first, registered strobes.
// Define UART_RX_MAJORITY_EN for a 3-sample majority vote around mid-bit.
module uart_rx #(
    parameter int PRESCALE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic [7:0] P_DATA,
    output logic       data_valid,
    output logic       par_err,
    output logic       stp_err
);

    localparam int EW = $clog2(PRESCALE);
    localparam logic [EW-1:0] LAST = EW'(PRESCALE - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [EW-1:0] SMP0 = EW'(PRESCALE / 2 - 1);
    localparam logic [EW-1:0] SMP1 = EW'(PRESCALE / 2);
    localparam logic [EW-1:0] DEC  = EW'(PRESCALE / 2 + 1);
`else
    localparam logic [EW-1:0] DEC  = EW'(PRESCALE / 2);
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_meta_d;
    logic            rx_s_q, rx_s_d;
    logic [EW-1:0]   edge_cnt_q, edge_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      data_q, data_d;
    logic            par_en_q, par_en_d;
    logic            par_typ_q, par_typ_d;
    logic            par_bad_q, par_bad_d;
    logic [7:0]      p_data_q, p_data_d;
    logic            dv_q, dv_d;
    logic            pe_q, pe_d;
    logic            se_q, se_d;
`ifdef UART_RX_MAJORITY_EN
    logic [1:0]      samp_q, samp_d;
`endif

    logic samp;
    logic dec;
    logic wrap;

    assign dec  = (edge_cnt_q == DEC);
    assign wrap = (edge_cnt_q == LAST);

`ifdef UART_RX_MAJORITY_EN
    // Two early samples are held; the third is the live value at the decision point.
    assign samp = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s_q) | (samp_q[0] & rx_s_q);

    always_comb begin
        samp_d = samp_q;
        if (edge_cnt_q == SMP0) samp_d[1] = rx_s_q;
        if (edge_cnt_q == SMP1) samp_d[0] = rx_s_q;
    end
`else
    assign samp = rx_s_q;
`endif

    always_comb begin
        rx_meta_d  = RX_IN;
        rx_s_d     = rx_meta_q;
        state_d    = state_q;
        edge_cnt_d = wrap ? '0 : edge_cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_bad_d  = par_bad_q;
        p_data_d   = p_data_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                if (!rx_s_q) begin
                    state_d   = START;
                    par_bad_d = 1'b0;
                end
            end
            START: begin
                if (dec && samp) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                end else begin
                    // Frame format is frozen once a genuine start bit is confirmed.
                    if (dec) begin
                        par_en_d  = PAR_EN;
                        par_typ_d = PAR_TYP;
                    end
                    if (wrap) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (dec) data_d = {samp, data_q[7:1]};
                if (wrap) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (dec) par_bad_d = samp ^ (^data_q) ^ par_typ_q;
                if (wrap) state_d = STOP;
            end
            STOP: begin
                // Leave mid-stop-bit so a back-to-back start edge is not missed.
                if (dec) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                    se_d       = ~samp;
                    pe_d       = par_bad_q;
                    if (samp && !par_bad_q) begin
                        dv_d     = 1'b1;
                        p_data_d = data_q;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            samp_q     <= 2'b11;
`endif
        end else begin
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_bad_q  <= par_bad_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
`ifdef UART_RX_MAJORITY_EN
            samp_q     <= samp_d;
`endif
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = dv_q;
    assign par_err    = pe_q;
    assign stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level outcome model (queue of expected strobes) checked every cycle.
// Honours UART_RX_MAJORITY_EN for the glitch expectation and latency.
module tb_uart_rx;

    localparam int P = 8;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT_BASE  = 2 + 9 * P + P / 2 + 2;
    localparam int LIT_LAT0  = 80;
    localparam logic [7:0] GLITCH_LIT = 8'hFF;
`else
    localparam int LAT_BASE  = 2 + 9 * P + P / 2 + 1;
    localparam int LIT_LAT0  = 79;
    localparam logic [7:0] GLITCH_LIT = 8'hF7;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx #(.PRESCALE(P)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint     cyc;
        longint     c0;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] data;
        logic [7:0] lit;
        int         lit_lat;
    } exp_t;

    exp_t       exp_q[$];
    longint     cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_pdata = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
        end
    endtask

    task automatic chk_tol(input string name, input longint act, input longint req, input int tol);
        longint diff;
        diff = (act > req) ? act - req : req - act;
        checks++;
        if (diff > tol) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d+-%0d", name, act, req, tol);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            exp_q.delete();
            model_pdata = 8'h00;
            chk("rst_pdata", longint'(P_DATA), 0);
            chk("rst_strobes", longint'({data_valid, par_err, stp_err}), 0);
        end else if (data_valid || par_err || stp_err) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe dv=%0b pe=%0b se=%0b required none cyc=%0d",
                         data_valid, par_err, stp_err, cyc);
            end else begin
                e = exp_q.pop_front();
                chk_tol("strobe_time", cyc, e.cyc, 1);
                chk("strobes", longint'({data_valid, par_err, stp_err}), longint'({e.dv, e.pe, e.se}));
                if (e.dv) model_pdata = e.data;
                chk("p_data_model", longint'(P_DATA), longint'(model_pdata));
                chk("p_data_literal", longint'(P_DATA), longint'(e.lit));
                if (e.lit_lat >= 0) chk_tol("latency", cyc - e.c0 - 1, e.lit_lat, 1);
            end
        end else begin
            if (exp_q.size() > 0 && cyc > exp_q[0].cyc + 1) begin
                checks++;
                errors++;
                $display("FAIL missing_strobe actual=none required_at=%0d cyc=%0d", exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            chk("p_data_hold", longint'(P_DATA), longint'(model_pdata));
        end
    end

    task automatic hold(input logic v, input int n);
        RX_IN = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // gbit >= 0 places a one-cycle low pulse mid-way through that data bit
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic flip, input logic stop, input int gbit,
                              input logic [7:0] lit, input int lit_lat);
        exp_t e;
        logic [7:0] md;
        md = d;
`ifndef UART_RX_MAJORITY_EN
        if (gbit >= 0) md[gbit[2:0]] = 1'b0;
`endif
        PAR_EN    = pen;
        PAR_TYP   = ptyp;
        e.c0      = cyc;
        e.cyc     = cyc + 1 + LAT_BASE + (pen ? P : 0);
        e.se      = ~stop;
        e.pe      = pen & flip;
        e.dv      = stop & ~(pen & flip);
        e.data    = md;
        e.lit     = lit;
        e.lit_lat = lit_lat;
        exp_q.push_back(e);
        hold(1'b0, P);
        for (int i = 0; i < 8; i++) begin
            if (i == gbit) begin
                hold(1'b1, P / 2 + 1);
                hold(1'b0, 1);
                hold(1'b1, P / 2 - 2);
            end else begin
                hold(d[i], P);
            end
        end
        if (pen) hold(^d ^ ptyp ^ flip, P);
        hold(stop, P);
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        hold(1'b1, 10);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 8'hA5, LIT_LAT0); hold(1'b1, 16);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, 8'h3C, -1);       hold(1'b1, 16);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, 8'h3C, -1);       hold(1'b1, 16);
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, -1, 8'h01, -1);       hold(1'b1, 16);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1, 8'h01, -1);       hold(1'b1, 24);
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1, 8'h12, -1);       hold(1'b1, 16);

        // short low pulse on the line must be rejected as a false start
        hold(1'b0, 2);
        hold(1'b1, 24);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, -1, 8'h7E, -1);       hold(1'b1, 16);

        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, -1, 8'h11, -1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, -1, 8'h22, -1);       hold(1'b1, 16);

        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, -1, 8'h22, -1);       hold(1'b1, 24);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 3, GLITCH_LIT, -1);   hold(1'b1, 16);

        // abort a frame mid-data with reset, then receive normally
        PAR_EN = 1'b0;
        hold(1'b0, P);
        hold(1'b1, P);
        hold(1'b0, P);
        hold(1'b1, 4);
        rst = 1'b0;
        hold(1'b1, 10);
        rst = 1'b1;
        hold(1'b1, 10);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1, 8'h5A, -1);       hold(1'b1, 40);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
